fuser_fold_sequencer: RTL and testbench
=======================================

# fuser_fold_sequencer

Transmit side of the folded fuser interface. Captures one hypervector per modality with a valid/ready handshake and streams them as FOLD_WIDTH-bit slices, with matching fold indices, into the folded fuser. Slices go out fold-major and modality-minor, and a one-cycle `done` pulse follows the last slice. It sits between the per-modality spatial encoders and the fuser, and shares the fuser's clock and reset.

## Interface
- NUM_FOLDS, default 4: number of folds; 1 means no folding.
- NUM_FOLDS_WIDTH, default 2: ceillog(NUM_FOLDS), minimum 1.
- FOLD_WIDTH, default 500: slice width; NUM_FOLDS*FOLD_WIDTH == `HV_DIMENSION`, checked by elaboration assertion.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- hvin_valid  in  1  modality HVs present.
- hvin_ready  out  1  block can capture.
- hvin  in  `NUM_MODALITY`*`HV_DIMENSION`  modality m at hvin[m*`HV_DIMENSION` +: `HV_DIMENSION`].
- fold_valid  out  1  slice valid; drives fuser hvin_valid.
- fold_ready  in  1  fuser ready; fuser ties it to 1, but stalls are honoured.
- fold_hv  out  FOLD_WIDTH  current slice.
- fold_counter  out  NUM_FOLDS_WIDTH  fold index of the current slice.
- done  out  1  one-cycle end-of-vector pulse.

## Operation
- Reset values, applied at the first posedge with rst high:
  - state IDLE, all counters 0.
  - hvin_ready=1 from the following cycle.
  - fold_valid=0, done=0, fold_counter=0, fold_hv=0.
- IDLE:
  - hvin_ready=1.
  - On hvin_valid, register all `NUM_MODALITY` HVs, load slice (fold 0, mod 0) into fold_hv, then go to SEND.
- SEND:
  - fold_valid=1, hvin_ready=0.
  - Slice order: for f = 0..NUM_FOLDS-1, for m = 0..`NUM_MODALITY`-1, emit hv[m][f*FOLD_WIDTH +: FOLD_WIDTH] with fold_counter=f.
  - On a fold_valid && fold_ready handshake, advance mod_idx. On wrap, zero mod_idx and increment fold_idx. Register the next slice.
  - The handshake on (NUM_FOLDS-1, `NUM_MODALITY`-1) goes to DONE instead.
- DONE: exactly one cycle.
  - done=1, fold_valid=0, hvin_ready=0.
  - Next state IDLE.
- Backpressure: while fold_valid && !fold_ready, fold_hv and fold_counter hold stable and no counter advances.
- Downstream framing: the fuser counts every valid modulo 3. The block therefore never emits a partial fold group, except when aborted by rst, which also resets the fuser.
- Reset mid-SEND or mid-DONE: abandon the vector immediately and return to IDLE with reset values; no done pulse.
- hvin_valid while not in IDLE is ignored; the upstream producer holds it.
- Input data is registered, so upstream may change hvin the cycle after capture.
- Arithmetic:
  - fold_idx is NUM_FOLDS_WIDTH bits and mod_idx is `NUM_MODALITY_WIDTH` bits.
  - The slice offset f*FOLD_WIDTH is computed at integer width; no truncation.
- NUM_FOLDS=1: three slices of full width, fold_counter constantly 0.

## Timing
- Capture handshake at cycle T → first slice valid at T+1.
- Zero stalls: slices occupy T+1 .. T+3*NUM_FOLDS, done at T+3*NUM_FOLDS+1, hvin_ready high at T+3*NUM_FOLDS+2.
- Each stall cycle delays all later events by one.
- done is asserted exactly one cycle after the final slice handshake. This lets the fuser's two-stage write of the last fold land on the same edge as its hvout_valid.
- Throughput: one vector per 3*NUM_FOLDS+2 cycles at full rate.
- All outputs are registered or decoded from the state register; no combinational path from fold_ready or hvin_valid to any output.

## Structure
- `HV_DIMENSION`, `NUM_MODALITY`, `NUM_MODALITY_WIDTH` come from const.vh. Add no new macros.
- State enum (IDLE/SEND/DONE) is local to the module.
- One sub-module, hv_fold_slicer: combinational select of a FOLD_WIDTH slice given (mod_idx, fold_idx) from the captured HV bank, parameterised like the parent. The parent registers its output into fold_hv.

## Test plan
- Reset then idle: after rst, hvin_ready=1, fold_valid=0, done=0, fold_hv=0 for 10 cycles.
- Ordering, HV_DIMENSION=2000, NUM_FOLDS=4, FOLD_WIDTH=500, fold_ready=1:
  - Stimulus: mod m, bit i = (i/500==m) ^ (i%2).
  - Required: 12 slices on T+1..T+12, fold_counter 0,0,0,1,1,1,2,2,2,3,3,3, each slice matching the golden value.
  - Required: done only at T+13, hvin_ready at T+14.
- Backpressure: drop fold_ready at slice 5 for 3 cycles → slice 5 and fold_counter=1 held for 4 cycles; done moves to T+16.
- Reset mid-SEND: assert rst after slice 7 → next cycle fold_valid=0, done never pulses. A fresh vector then starts at fold 0, mod 0.
- End-to-end with the fuser: random 3 HVs → fuser hvout equals bitwise majority of the three at the cycle hvout_valid=1. Repeat with NUM_FOLDS=1, FOLD_WIDTH=2000.
- Back-to-back: hold hvin_valid with two vectors → second capture exactly at T+14, no slice gap or duplication.

Source files
------------

// File: rtl/fuser_fold_sequencer_pkg.sv
// Shared dimensions for the folded fuser transmit path.
package fuser_fold_sequencer_pkg;

  localparam int HV_DIMENSION       = 2000;
  localparam int NUM_MODALITY       = 3;
  localparam int NUM_MODALITY_WIDTH = 2;

  // Total slices emitted for one captured vector set.
  function automatic int slices_per_vector(input int num_folds);
    return num_folds * NUM_MODALITY;
  endfunction

endpackage

// File: rtl/fuser_fold_sequencer_if.sv
// Capture handshake from the spatial encoders and folded slice stream to the fuser.
interface fuser_fold_sequencer_if
  import fuser_fold_sequencer_pkg::*;
#(
  parameter int NUM_FOLDS_WIDTH = 2,
  parameter int FOLD_WIDTH      = 500
) ();

  logic                                 hvin_valid;
  logic                                 hvin_ready;
  logic [NUM_MODALITY*HV_DIMENSION-1:0] hvin;
  logic                                 fold_valid;
  logic                                 fold_ready;
  logic [FOLD_WIDTH-1:0]                fold_hv;
  logic [NUM_FOLDS_WIDTH-1:0]           fold_counter;
  logic                                 done;

  // The sequencer side.
  modport master (
    input  hvin_valid, hvin, fold_ready,
    output hvin_ready, fold_valid, fold_hv, fold_counter, done
  );

  // The encoder/fuser environment side.
  modport slave (
    output hvin_valid, hvin, fold_ready,
    input  hvin_ready, fold_valid, fold_hv, fold_counter, done
  );

endinterface

// File: rtl/fuser_fold_sequencer_hv_fold_slicer.sv
// Combinational pick of one FOLD_WIDTH slice out of the captured modality bank.
module hv_fold_slicer
  import fuser_fold_sequencer_pkg::*;
#(
  parameter int NUM_FOLDS       = 4,
  parameter int NUM_FOLDS_WIDTH = 2,
  parameter int FOLD_WIDTH      = 500
) (
  input  logic [NUM_MODALITY*HV_DIMENSION-1:0] hv_bank,
  input  logic [NUM_MODALITY_WIDTH-1:0]        mod_idx,
  input  logic [NUM_FOLDS_WIDTH-1:0]           fold_idx,
  output logic [FOLD_WIDTH-1:0]                slice
);

  int offset;

  // Index arithmetic in int so the offset never truncates; out-of-range indices read zero.
  always_comb begin
    slice  = '0;
    offset = int'(mod_idx) * HV_DIMENSION + int'(fold_idx) * FOLD_WIDTH;
    if (int'(fold_idx) < NUM_FOLDS && int'(mod_idx) < NUM_MODALITY) begin
      slice = hv_bank[offset +: FOLD_WIDTH];
    end
  end

endmodule

// File: rtl/fuser_fold_sequencer.sv
// Transmit side of the folded fuser: captures all modality HVs, then streams
// them fold-major / modality-minor as FOLD_WIDTH slices, then pulses done.
//
//   state  | meaning
//   S_IDLE | ready to capture a new modality set
//   S_SEND | presenting slice (fold_idx, mod_idx) on fold_hv
//   S_DONE | one-cycle end-of-vector pulse
module fuser_fold_sequencer
  import fuser_fold_sequencer_pkg::*;
#(
  parameter int NUM_FOLDS       = 4,
  parameter int NUM_FOLDS_WIDTH = 2,
  parameter int FOLD_WIDTH      = 500
) (
  input logic                    clk,
  input logic                    rst,
  fuser_fold_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  localparam logic [NUM_FOLDS_WIDTH-1:0]    FOLD_LAST = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
  localparam logic [NUM_MODALITY_WIDTH-1:0] MOD_LAST  = NUM_MODALITY_WIDTH'(NUM_MODALITY - 1);

  if (NUM_FOLDS * FOLD_WIDTH != HV_DIMENSION) begin : g_bad_fold_geometry
    $error("fuser_fold_sequencer: NUM_FOLDS*FOLD_WIDTH must equal HV_DIMENSION");
  end

  state_t                               state, state_nxt;
  logic [NUM_MODALITY*HV_DIMENSION-1:0] hv_bank;
  logic [NUM_MODALITY*HV_DIMENSION-1:0] slice_src;
  logic [NUM_FOLDS_WIDTH-1:0]           fold_idx, fold_idx_nxt;
  logic [NUM_MODALITY_WIDTH-1:0]        mod_idx, mod_idx_nxt;
  logic                                 capture;
  logic                                 load;
  logic [FOLD_WIDTH-1:0]                slice;
  logic [FOLD_WIDTH-1:0]                fold_hv_q;
  logic [NUM_FOLDS_WIDTH-1:0]           fold_counter_q;

  // On capture the first slice comes straight from hvin, since the bank is not yet loaded.
  assign slice_src = capture ? bus.hvin : hv_bank;

  hv_fold_slicer #(
    .NUM_FOLDS      (NUM_FOLDS),
    .NUM_FOLDS_WIDTH(NUM_FOLDS_WIDTH),
    .FOLD_WIDTH     (FOLD_WIDTH)
  ) u_slicer (
    .hv_bank (slice_src),
    .mod_idx (mod_idx_nxt),
    .fold_idx(fold_idx_nxt),
    .slice   (slice)
  );

  // Next state and index advance; indices only move on a slice handshake.
  always_comb begin
    state_nxt    = state;
    fold_idx_nxt = fold_idx;
    mod_idx_nxt  = mod_idx;
    capture      = 1'b0;
    load         = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.hvin_valid) begin
          capture      = 1'b1;
          load         = 1'b1;
          fold_idx_nxt = '0;
          mod_idx_nxt  = '0;
          state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.fold_ready) begin
          if (fold_idx == FOLD_LAST && mod_idx == MOD_LAST) begin
            fold_idx_nxt = '0;
            mod_idx_nxt  = '0;
            state_nxt    = S_DONE;
          end else begin
            load = 1'b1;
            if (mod_idx == MOD_LAST) begin
              mod_idx_nxt  = '0;
              fold_idx_nxt = fold_idx + NUM_FOLDS_WIDTH'(1);
            end else begin
              mod_idx_nxt = mod_idx + NUM_MODALITY_WIDTH'(1);
            end
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, indices, captured bank and the registered slice outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      fold_idx       <= '0;
      mod_idx        <= '0;
      hv_bank        <= '0;
      fold_hv_q      <= '0;
      fold_counter_q <= '0;
    end else begin
      state    <= state_nxt;
      fold_idx <= fold_idx_nxt;
      mod_idx  <= mod_idx_nxt;
      if (capture) begin
        hv_bank <= bus.hvin;
      end
      if (load) begin
        fold_hv_q      <= slice;
        fold_counter_q <= fold_idx_nxt;
      end
    end
  end

  assign bus.hvin_ready   = (state == S_IDLE);
  assign bus.fold_valid   = (state == S_SEND);
  assign bus.done         = (state == S_DONE);
  assign bus.fold_hv      = fold_hv_q;
  assign bus.fold_counter = fold_counter_q;

endmodule

// File: tb/tb_fuser_fold_sequencer.sv
// Bench for fuser_fold_sequencer: queue-based slice model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fuser_fold_sequencer;
  import fuser_fold_sequencer_pkg::*;

  localparam int NF  = 4;
  localparam int FW  = 500;
  localparam int HVW = NUM_MODALITY * HV_DIMENSION;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fuser_fold_sequencer_if #(.NUM_FOLDS_WIDTH(2), .FOLD_WIDTH(FW))           bus0 ();
  fuser_fold_sequencer_if #(.NUM_FOLDS_WIDTH(1), .FOLD_WIDTH(HV_DIMENSION)) bus1 ();

  fuser_fold_sequencer #(.NUM_FOLDS(NF), .NUM_FOLDS_WIDTH(2), .FOLD_WIDTH(FW)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  fuser_fold_sequencer #(.NUM_FOLDS(1), .NUM_FOLDS_WIDTH(1), .FOLD_WIDTH(HV_DIMENSION)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_hv(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic check_wide(input string name, input logic [HV_DIMENSION-1:0] act,
                            input logic [HV_DIMENSION-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  // Model: a captured vector becomes a queue of slices in emission order; the head
  // is what must be on the bus, a handshake pops it, an emptied queue means done next.
  typedef struct {
    logic [FW-1:0] hv;
    int            f;
  } slice_t;

  slice_t mq[$];
  bit     m_known = 1'b0;
  bit     m_idle  = 1'b1;
  bit     m_done  = 1'b0;

  always @(posedge clk) begin : model
    slice_t s;
    if (rst) begin
      mq.delete();
      m_known = 1'b1;
      m_idle  = 1'b1;
      m_done  = 1'b0;
    end else if (m_known) begin
      if (m_done) begin
        m_done = 1'b0;
        m_idle = 1'b1;
      end else if (mq.size() > 0) begin
        if (bus0.fold_ready) begin
          void'(mq.pop_front());
          if (mq.size() == 0) m_done = 1'b1;
        end
      end else if (m_idle && bus0.hvin_valid) begin
        for (int f = 0; f < NF; f++) begin
          for (int m = 0; m < NUM_MODALITY; m++) begin
            s.hv = bus0.hvin[m*HV_DIMENSION + f*FW +: FW];
            s.f  = f;
            mq.push_back(s);
          end
        end
        m_idle = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (m_known) begin
      check_int("hvin_ready", int'(bus0.hvin_ready), int'(m_idle));
      check_int("fold_valid", int'(bus0.fold_valid), int'(mq.size() > 0));
      check_int("done", int'(bus0.done), int'(m_done));
      if (mq.size() > 0) begin
        check_hv("fold_hv", bus0.fold_hv, mq[0].hv);
        check_int("fold_counter", int'(bus0.fold_counter), mq[0].f);
      end
    end
  end

  logic          r_valid[64];
  logic          r_done[64];
  logic          r_ready[64];
  logic [FW-1:0] r_hv[64];
  logic [1:0]    r_fc[64];

  // Capture at the edge ending cycle T; entry n of the records is cycle T+n.
  task automatic run_vec(input logic [HVW-1:0] v, input logic [HVW-1:0] v2, input bit hold,
                         input int bp_s, input int bp_l, input int rst_at, input int ncyc);
    for (int i = 0; i < 64; i++) begin
      r_valid[i] = 1'b0; r_done[i] = 1'b0; r_ready[i] = 1'b0; r_hv[i] = '0; r_fc[i] = '0;
    end
    @(negedge clk);
    bus0.hvin       = v;
    bus0.hvin_valid = 1'b1;
    bus0.fold_ready = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      r_valid[n] = bus0.fold_valid;
      r_done[n]  = bus0.done;
      r_ready[n] = bus0.hvin_ready;
      r_hv[n]    = bus0.fold_hv;
      r_fc[n]    = bus0.fold_counter;
      if (n == 1) begin
        bus0.hvin       = hold ? v2 : ~v;
        bus0.hvin_valid = hold;
      end
      if (hold && n == 15) bus0.hvin_valid = 1'b0;
      bus0.fold_ready = !(n >= bp_s && n < bp_s + bp_l);
      rst = (n == rst_at);
    end
    bus0.fold_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic int count_valid(input int ncyc);
    int c = 0;
    for (int n = 1; n <= ncyc; n++) if (r_valid[n]) c++;
    return c;
  endfunction

  function automatic int count_done(input int ncyc);
    int c = 0;
    for (int n = 1; n <= ncyc; n++) if (r_done[n]) c++;
    return c;
  endfunction

  function automatic logic [HVW-1:0] rand_hv();
    logic [HVW-1:0] v;
    for (int i = 0; i < HVW; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [HV_DIMENSION-1:0] maj3(input logic [HVW-1:0] v);
    logic [HV_DIMENSION-1:0] a, b, c;
    a = v[0 +: HV_DIMENSION];
    b = v[HV_DIMENSION +: HV_DIMENSION];
    c = v[2*HV_DIMENSION +: HV_DIMENSION];
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [HVW-1:0]          gold, va, vb, vr;
  logic [HVW-1:0]          rebuilt;
  logic [FW-1:0]           pat_eq, pat_ne;
  logic [HV_DIMENSION-1:0] w_hv[8];
  logic                    w_valid[8];
  logic                    w_done[8];
  logic                    w_ready[8];
  logic                    w_fc[8];
  int                      fold_seq[12];

  initial begin
    bus0.hvin_valid = 1'b0; bus0.hvin = '0; bus0.fold_ready = 1'b1;
    bus1.hvin_valid = 1'b0; bus1.hvin = '0; bus1.fold_ready = 1'b1;
    fold_seq = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    pat_eq = {250{2'b01}};
    pat_ne = {250{2'b10}};
    for (int m = 0; m < NUM_MODALITY; m++)
      for (int i = 0; i < HV_DIMENSION; i++)
        gold[m*HV_DIMENSION + i] = ((i / FW) == m) ^ (i % 2 == 1);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset then idle.
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_int("idle_hvin_ready", int'(bus0.hvin_ready), 1);
      check_int("idle_fold_valid", int'(bus0.fold_valid), 0);
      check_int("idle_done", int'(bus0.done), 0);
      check_hv("idle_fold_hv", bus0.fold_hv, '0);
    end
    check_int("idle_nf1_hvin_ready", int'(bus1.hvin_ready), 1);

    // Ordering at full rate.
    run_vec(gold, '0, 1'b0, 0, 0, 0, 16);
    check_int("order_valid_count", count_valid(16), 12);
    for (int k = 0; k < 12; k++) begin
      check_int("order_valid", int'(r_valid[k+1]), 1);
      check_int("order_fold_counter", int'(r_fc[k+1]), fold_seq[k]);
      check_hv("order_slice", r_hv[k+1], (k / 3 == k % 3) ? pat_eq : pat_ne);
    end
    check_int("order_done_at_13", int'(r_done[13]), 1);
    check_int("order_done_count", count_done(16), 1);
    check_int("order_ready_at_13", int'(r_ready[13]), 0);
    check_int("order_ready_at_14", int'(r_ready[14]), 1);

    // Backpressure on slice 5 for three cycles.
    run_vec(gold, '0, 1'b0, 5, 3, 0, 20);
    check_int("bp_valid_count", count_valid(20), 15);
    for (int n = 5; n <= 8; n++) begin
      check_hv("bp_hold_slice", r_hv[n], pat_eq);
      check_int("bp_hold_fold", int'(r_fc[n]), 1);
    end
    check_hv("bp_next_slice", r_hv[9], pat_ne);
    check_int("bp_done_at_16", int'(r_done[16]), 1);
    check_int("bp_done_count", count_done(20), 1);
    check_int("bp_ready_at_17", int'(r_ready[17]), 1);

    // Reset mid-SEND after slice 7, then a fresh vector.
    va = rand_hv();
    run_vec(va, '0, 1'b0, 0, 0, 7, 14);
    check_int("rst_valid_at_7", int'(r_valid[7]), 1);
    check_int("rst_valid_at_8", int'(r_valid[8]), 0);
    check_int("rst_no_done", count_done(14), 0);
    check_int("rst_ready_at_8", int'(r_ready[8]), 1);
    vb = rand_hv();
    run_vec(vb, '0, 1'b0, 0, 0, 0, 16);
    check_int("fresh_fold0", int'(r_fc[1]), 0);
    check_hv("fresh_slice0", r_hv[1], vb[0 +: FW]);
    check_int("fresh_done_at_13", int'(r_done[13]), 1);

    // Back-to-back with hvin_valid held, plus majority of the reassembled slices.
    va = rand_hv();
    vb = rand_hv();
    run_vec(va, vb, 1'b1, 0, 0, 0, 30);
    check_int("b2b_valid_count", count_valid(30), 24);
    check_int("b2b_valid_at_12", int'(r_valid[12]), 1);
    check_int("b2b_gap_13", int'(r_valid[13]), 0);
    check_int("b2b_gap_14", int'(r_valid[14]), 0);
    check_int("b2b_valid_at_15", int'(r_valid[15]), 1);
    check_hv("b2b_second_first_slice", r_hv[15], vb[0 +: FW]);
    check_int("b2b_second_fold0", int'(r_fc[15]), 0);
    check_int("b2b_done_at_27", int'(r_done[27]), 1);
    check_int("b2b_done_count", count_done(30), 2);
    rebuilt = '0;
    for (int k = 0; k < 12; k++)
      rebuilt[(k % 3)*HV_DIMENSION + (k / 3)*FW +: FW] = r_hv[k+1];
    check_wide("b2b_majority", maj3(rebuilt), maj3(va));

    // No folding: three full-width slices, fold_counter constantly 0.
    vr = rand_hv();
    @(negedge clk);
    bus1.hvin = vr;
    bus1.hvin_valid = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      w_valid[n] = bus1.fold_valid;
      w_done[n]  = bus1.done;
      w_ready[n] = bus1.hvin_ready;
      w_hv[n]    = bus1.fold_hv;
      w_fc[n]    = bus1.fold_counter;
      if (n == 1) begin
        bus1.hvin_valid = 1'b0;
        bus1.hvin = ~vr;
      end
    end
    rebuilt = '0;
    for (int m = 0; m < 3; m++) begin
      check_int("nf1_valid", int'(w_valid[m+1]), 1);
      check_int("nf1_fold_counter", int'(w_fc[m+1]), 0);
      check_wide("nf1_slice", w_hv[m+1], vr[m*HV_DIMENSION +: HV_DIMENSION]);
      rebuilt[m*HV_DIMENSION +: HV_DIMENSION] = w_hv[m+1];
    end
    check_int("nf1_valid_at_4", int'(w_valid[4]), 0);
    check_int("nf1_done_at_4", int'(w_done[4]), 1);
    check_int("nf1_ready_at_5", int'(w_ready[5]), 1);
    check_wide("nf1_majority", maj3(rebuilt), maj3(vr));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
